pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the five-stage pipeline (F, D, E, M, W).
- Drives the per-register enable/flush of the F_TO_D, D_TO_E, E_TO_M and M_TO_W stage registers and the PC update, from fetch/data-memory busy, load-use, mul/div busy and branch redirect.
- Holds a redirect that arrives while an instruction fetch is in flight, squashes the stale fetched instruction, then applies the redirect.

---
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush controller for a five-stage pipeline. It holds a
//               redirect while an instruction fetch is still in flight.
//               Optional macro PIPE_CTRL_PERF_EN adds the stall and flush
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_busy,
  input  logic            d_busy,
  input  logic            md_busy,
  input  logic            lu_hazard,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            pc_en,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target,
  output logic            fd_en,
  output logic            de_en,
  output logic            em_en,
  output logic            mw_en,
  output logic            fd_flush,
  output logic            de_flush,
  output logic            em_flush,
  output logic            mw_flush
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  localparam logic [0:0] c_IDLE       = 1'b0;
  localparam logic [0:0] c_WAIT_FETCH = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_stateNext;
  logic [XLEN-1:0] r_pendPc;
  logic [XLEN-1:0] w_pendPcNext;
  logic            w_accept;

  always_comb begin
    pc_en        = 1'b1;
    pc_redirect  = 1'b0;
    pc_target    = '0;
    fd_en        = 1'b1;
    de_en        = 1'b1;
    em_en        = 1'b1;
    mw_en        = 1'b1;
    fd_flush     = 1'b0;
    de_flush     = 1'b0;
    em_flush     = 1'b0;
    mw_flush     = 1'b0;
    w_accept     = 1'b0;
    w_stateNext  = r_state;
    w_pendPcNext = r_pendPc;

    if (reset) begin
      pc_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = 1'b1;
      mw_flush = 1'b1;
    end else begin
      if (d_busy) begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        de_en    = 1'b0;
        em_en    = 1'b0;
        mw_flush = 1'b1;
      end else if (md_busy) begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        de_en    = 1'b0;
        em_flush = 1'b1;
      end else if (lu_hazard) begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        de_flush = 1'b1;
      end else if (redirect_valid) begin
        // E is advancing, so the redirect is accepted; a late one in
        // WAIT_FETCH simply replaces the pending target.
        w_accept = 1'b1;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        if (!i_busy) begin
          pc_redirect = 1'b1;
          pc_target   = redirect_pc;
          w_stateNext = c_IDLE;
        end else begin
          pc_en        = 1'b0;
          w_pendPcNext = redirect_pc;
          w_stateNext  = c_WAIT_FETCH;
        end
      end else if (i_busy) begin
        pc_en    = 1'b0;
        fd_flush = 1'b1;
      end

      // While waiting, the front end ignores D..W stalls: F_TO_D keeps
      // loading bubbles and the PC moves only once the fetch returns.
      if (r_state == c_WAIT_FETCH && !w_accept) begin
        fd_en    = 1'b1;
        fd_flush = 1'b1;
        pc_en    = !i_busy;
        if (!i_busy) begin
          pc_redirect = 1'b1;
          pc_target   = r_pendPc;
          w_stateNext = c_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_pendPc <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_pendPc <= w_pendPcNext;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_flushEvents;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCycles <= '0;
      r_flushEvents <= '0;
    end else begin
      if (!pc_en && r_stallCycles != {CNT_W{1'b1}})
        r_stallCycles <= r_stallCycles + 1'b1;
      if (w_accept && r_flushEvents != {CNT_W{1'b1}})
        r_flushEvents <= r_flushEvents + 1'b1;
    end
  end

  assign stall_cycles = r_stallCycles;
  assign flush_events = r_flushEvents;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//               followed by random traffic against a priority-rule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_busy, d_busy, md_busy, lu_hazard, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            pc_en, pc_redirect;
  logic [XLEN-1:0] pc_target;
  logic            fd_en, de_en, em_en, mw_en;
  logic            fd_flush, de_flush, em_flush, mw_flush;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [CNT_W-1:0] mStall, mFlush;
`endif

  int nChecks = 0;
  int nPass   = 0;

  // Model state: is a redirect parked behind an in-flight fetch, and where to.
  logic            mPending;
  logic [XLEN-1:0] mTarget;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .i_busy(i_busy), .d_busy(d_busy),
    .md_busy(md_busy), .lu_hazard(lu_hazard), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc_en(pc_en), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
    .mw_en(mw_en), .fd_flush(fd_flush), .de_flush(de_flush),
    .em_flush(em_flush), .mw_flush(mw_flush)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  // ctrl = {pc_en, pc_redirect, en[fd,de,em,mw], flush[fd,de,em,mw]}
  task automatic model(output logic [9:0] ctrl, output logic [XLEN-1:0] tgt,
                       output logic acc);
    logic [4:1] en, fl;
    logic       pcE, pcR;
    int         k;
    tgt = '0;
    acc = 1'b0;
    pcR = 1'b0;
    if (reset) begin
      en  = 4'hF;
      fl  = 4'hF;
      pcE = 1'b0;
    end else begin
      // k = deepest stalled stage (D=1, E=2, M=3); registers up to k hold,
      // the one just downstream of it takes a bubble.
      k = d_busy ? 3 : md_busy ? 2 : lu_hazard ? 1 : 0;
      for (int r = 1; r <= 4; r++) begin
        en[r] = (r > k);
        fl[r] = (k > 0) && (r == k + 1);
      end
      pcE = (k == 0);
      acc = redirect_valid && (k == 0);
      if (acc) begin
        fl[1] = 1'b1;
        fl[2] = 1'b1;
      end
      if (mPending || acc) begin
        en[1] = 1'b1;
        fl[1] = 1'b1;
        pcE   = !i_busy;
        pcR   = !i_busy;
        if (!i_busy) tgt = acc ? redirect_pc : mTarget;
      end else if (k == 0 && i_busy) begin
        pcE   = 1'b0;
        fl[1] = 1'b1;
      end
    end
    ctrl = {pcE, pcR, en[1], en[2], en[3], en[4], fl[1], fl[2], fl[3], fl[4]};
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    nChecks++;
    assert (got === exp) nPass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // One cycle: drive, check at negedge, advance model at posedge.
  task automatic step(input logic rst, input logic ib, input logic db,
                      input logic mb, input logic lu, input logic rv,
                      input logic [XLEN-1:0] rpc);
    logic [9:0]      eCtrl;
    logic [XLEN-1:0] eTgt;
    logic            acc;
    reset = rst; i_busy = ib; d_busy = db; md_busy = mb;
    lu_hazard = lu; redirect_valid = rv; redirect_pc = rpc;
    @(negedge clk);
    model(eCtrl, eTgt, acc);
    check("ctrl", {54'd0, pc_en, pc_redirect, fd_en, de_en, em_en, mw_en,
                   fd_flush, de_flush, em_flush, mw_flush}, {54'd0, eCtrl});
    check("pc_target", pc_target, eTgt);
`ifdef PIPE_CTRL_PERF_EN
    check("stall_cycles", {32'd0, stall_cycles}, {32'd0, mStall});
    check("flush_events", {32'd0, flush_events}, {32'd0, mFlush});
`endif
    @(posedge clk);
    if (rst) begin
      mPending = 1'b0;
      mTarget  = '0;
`ifdef PIPE_CTRL_PERF_EN
      mStall = '0;
      mFlush = '0;
`endif
    end else begin
`ifdef PIPE_CTRL_PERF_EN
      if (!eCtrl[9] && mStall != '1) mStall++;
      if (acc && mFlush != '1) mFlush++;
`endif
      if (acc && ib) begin
        mPending = 1'b1;
        mTarget  = rpc;
      end else if (mPending && !ib) begin
        mPending = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    logic [XLEN-1:0] rpc;
    mPending = 1'b0;
    mTarget  = '0;
`ifdef PIPE_CTRL_PERF_EN
    mStall = '0;
    mFlush = '0;
`endif
    // Reset held two cycles, then quiet pipeline.
    step(1, 0, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, '0);
    // d_busy with concurrent lu_hazard, then lu_hazard alone.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 0, '0);
    step(0, 0, 0, 0, 1, 0, '0);
    step(0, 0, 0, 0, 0, 0, '0);
    // md_busy, and a redirect masked by a stall.
    step(0, 0, 0, 1, 0, 1, 64'hDEAD);
    step(0, 0, 0, 0, 0, 0, '0);
    // Redirect with fetch idle.
    step(0, 0, 0, 0, 0, 1, 64'h8000_0040);
    step(0, 0, 0, 0, 0, 0, '0);
    // Redirect with fetch in flight for 4 more cycles.
    step(0, 1, 0, 0, 0, 1, 64'h8000_0100);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, '0);
    // Same, with d_busy during the wait, then reset pulsed in cycle 2.
    step(0, 1, 0, 0, 0, 1, 64'h8000_0200);
    step(0, 1, 1, 0, 0, 0, '0);
    step(1, 1, 0, 0, 0, 0, '0);
    step(0, 1, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, '0);
    // Random traffic; hazards kept sparse so redirects actually land.
    for (int i = 0; i < 400; i++) begin
      rpc = {$urandom, $urandom};
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           rpc);
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
